// File: rtl/serializer_framed.sv
// Framed parallel-to-serial converter: each accepted word goes out as a sync pattern then the payload.
// Optional PARITY_EN macro appends one even-parity beat after the data phase.
module serializer_framed #(
    parameter int                DATA_W       = 32,
    parameter int                LANES        = 1,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(8'hA5),
    parameter bit                MSB_FIRST    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [LANES-1:0]  dout,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              dout_last
);

    localparam int SYNC_BEATS = SYNC_W / LANES;
    localparam int DATA_BEATS = DATA_W / LANES;
    localparam int CNT_MAX    = (SYNC_BEATS > DATA_BEATS) ? SYNC_BEATS : DATA_BEATS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BEATS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
`ifdef PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
`ifdef PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    beat;
    logic [SYNC_W-1:0]   sync_sr;
    logic [DATA_W-1:0]   data_sr;
`ifdef PARITY_EN
    logic                parity_q;
`endif
    logic                accept;

    // Lane 0 always takes the earliest bit still waiting in the register.
    function automatic logic [LANES-1:0] head_sync(input logic [SYNC_W-1:0] v);
        logic [LANES-1:0] h;
        for (int j = 0; j < LANES; j++) h[j] = MSB_FIRST ? v[SYNC_W-1-j] : v[j];
        return h;
    endfunction

    function automatic logic [SYNC_W-1:0] shift_sync(input logic [SYNC_W-1:0] v);
        return MSB_FIRST ? (v << LANES) : (v >> LANES);
    endfunction

    function automatic logic [LANES-1:0] head_data(input logic [DATA_W-1:0] v);
        logic [LANES-1:0] h;
        for (int j = 0; j < LANES; j++) h[j] = MSB_FIRST ? v[DATA_W-1-j] : v[j];
        return h;
    endfunction

    function automatic logic [DATA_W-1:0] shift_data(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? (v << LANES) : (v >> LANES);
    endfunction

    // s_ready is only ever high in IDLE or on a frame's final beat, so acceptance restarts cleanly.
    assign accept = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            sync_sr     <= '0;
            data_sr     <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            dout_last   <= 1'b0;
            s_ready     <= 1'b1;
`ifdef PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (accept) begin
            state       <= SYNC;
            beat        <= '0;
            dout        <= head_sync(SYNC_PATTERN);
            sync_sr     <= shift_sync(SYNC_PATTERN);
            data_sr     <= s_data;
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            dout_last   <= 1'b0;
            s_ready     <= 1'b0;
`ifdef PARITY_EN
            parity_q    <= ^s_data;
`endif
        end else begin
            case (state)
                SYNC: begin
                    frame_start <= 1'b0;
                    if (beat == SYNC_LAST) begin
                        state     <= DATA;
                        beat      <= '0;
                        dout      <= head_data(data_sr);
                        data_sr   <= shift_data(data_sr);
                        dout_last <= !HAS_PARITY && (DATA_BEATS == 1);
                        s_ready   <= !HAS_PARITY && (DATA_BEATS == 1);
                    end else begin
                        beat    <= beat + 1'b1;
                        dout    <= head_sync(sync_sr);
                        sync_sr <= shift_sync(sync_sr);
                    end
                end
                DATA: begin
                    if (beat == DATA_LAST) begin
`ifdef PARITY_EN
                        state     <= PARITY;
                        dout      <= LANES'(parity_q);
                        dout_last <= 1'b1;
                        s_ready   <= 1'b1;
`else
                        state      <= IDLE;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        s_ready    <= 1'b1;
`endif
                    end else begin
                        beat      <= beat + 1'b1;
                        dout      <= head_data(data_sr);
                        data_sr   <= shift_data(data_sr);
                        dout_last <= !HAS_PARITY && ((beat + 1'b1) == DATA_LAST);
                        s_ready   <= !HAS_PARITY && ((beat + 1'b1) == DATA_LAST);
                    end
                end
                default: begin
                    state       <= IDLE;
                    dout        <= '0;
                    dout_valid  <= 1'b0;
                    frame_start <= 1'b0;
                    dout_last   <= 1'b0;
                    s_ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_framed.sv
// Bench for serializer_framed: three configurations share one input stream and are
// compared every cycle against a frame/bit-index reference model.
module tb_serializer_framed;

    localparam int NI = 3;
    localparam int LN [NI] = '{1, 4, 1};
    localparam bit MS [NI] = '{1'b0, 1'b0, 1'b1};
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        rdy [NI];
    logic        vld [NI];
    logic        fs  [NI];
    logic        lst [NI];
    logic [7:0]  od  [NI];
    logic [0:0]  d0;
    logic [3:0]  d1;
    logic [0:0]  d2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int pos  [NI] = '{-1, -1, -1};
    logic [31:0] word [NI];

    serializer_framed #(.DATA_W(32), .LANES(1), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .MSB_FIRST(1'b0)) u_lsb1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data),
        .dout(d0), .dout_valid(vld[0]), .frame_start(fs[0]), .dout_last(lst[0]));

    serializer_framed #(.DATA_W(32), .LANES(4), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data),
        .dout(d1), .dout_valid(vld[1]), .frame_start(fs[1]), .dout_last(lst[1]));

    serializer_framed #(.DATA_W(32), .LANES(1), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .MSB_FIRST(1'b1)) u_msb1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy[2]), .s_data(s_data),
        .dout(d2), .dout_valid(vld[2]), .frame_start(fs[2]), .dout_last(lst[2]));

    assign od[0] = 8'(d0);
    assign od[1] = 8'(d1);
    assign od[2] = 8'(d2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(int n);
        return 8 / LN[n] + 32 / LN[n] + PB;
    endfunction

    function automatic bit model_ready(int n);
        return (pos[n] < 0) || (pos[n] == frame_len(n) - 1);
    endfunction

    // Expected {ready, valid, frame_start, last, dout} straight from the frame layout rules.
    function automatic logic [31:0] exp_out(int n);
        int lanes, sb, db, p, i;
        logic [31:0] w;
        logic [7:0]  sp;
        logic [7:0]  d;
        logic v, f, l;
        lanes = LN[n];
        sb = 8 / lanes;
        db = 32 / lanes;
        p  = pos[n];
        w  = word[n];
        sp = 8'hA5;
        d = '0; v = 1'b0; f = 1'b0; l = 1'b0;
        if (p >= 0) begin
            v = 1'b1;
            f = (p == 0);
            l = (p == frame_len(n) - 1);
            if (p < sb) begin
                for (int j = 0; j < lanes; j++) begin
                    i = p * lanes + j;
                    d[j] = MS[n] ? sp[7 - i] : sp[i];
                end
            end else if (p < sb + db) begin
                for (int j = 0; j < lanes; j++) begin
                    i = (p - sb) * lanes + j;
                    d[j] = MS[n] ? w[31 - i] : w[i];
                end
            end else begin
                d[0] = ^w;
            end
        end
        return {20'b0, model_ready(n), v, f, l, d};
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < NI; n++) begin
            if (rst) begin
                pos[n] <= -1;
            end else if (s_valid && model_ready(n)) begin
                word[n] <= s_data;
                pos[n]  <= 0;
            end else if (pos[n] >= 0) begin
                pos[n] <= (pos[n] == frame_len(n) - 1) ? -1 : pos[n] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < NI; n++) begin
                check($sformatf("beat[%0d]", n), {20'b0, rdy[n], vld[n], fs[n], lst[n], od[n]}, exp_out(n));
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the lanes=1 LSB instance accepted w.
    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 0;
        s_valid = 1'b1;
        s_data  = w;
        for (int c = 0; c < 200; c++) begin
            if (model_ready(0)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] sync_lsb;
        logic [31:0] expd;
        sync_lsb = 8'hA5;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_valid", 32'(vld[0]), 32'd0);
        check("rst_dout", 32'(od[0]), 32'd0);
        @(negedge clk);

        // Single word 1: literal bit timeline of the default configuration.
        send(32'h0000_0001);
        for (int c = 1; c <= 40; c++) begin
            expd = (c <= 8) ? 32'(sync_lsb[c-1]) : ((c == 9) ? 32'd1 : 32'd0);
            check($sformatf("w1_dout_c%0d", c), 32'(od[0]), expd);
            if (c == 1)  check("w1_fstart", 32'(fs[0]), 32'd1);
            if (c == 40) check("w1_last", 32'(lst[0]), 32'd1);
            @(negedge clk);
        end
        check("w1_idle_valid", 32'(vld[0]), 32'd0);
        repeat (20) @(negedge clk);

        // Back-to-back with s_valid held high.
        send(32'hFFFF_FFFF);
        s_valid = 1'b1;
        s_data  = 32'h0000_0000;
        repeat (39) @(negedge clk);
        check("b2b_ready40", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        check("b2b_fstart41", 32'(fs[0]), 32'd1);
        check("b2b_valid41", 32'(vld[0]), 32'd1);
        s_valid = 1'b0;
        repeat (60) @(negedge clk);

        send(32'h8765_4321);
        repeat (45) @(negedge clk);
        send(32'h8000_0000);
        repeat (45) @(negedge clk);

        // Reset on the fifth data beat aborts the frame.
        send(32'h1234_5678);
        for (int c = 0; c < 100 && pos[0] != 12; c++) @(negedge clk);
        check("mid_pos_reached", 32'(pos[0]), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(vld[0]), 32'd0);
        check("mid_rst_ready", 32'(rdy[0]), 32'd1);
        check("mid_rst_dout", 32'(od[0]), 32'd0);
        send(32'hCAFE_F00D);
        check("mid_new_fstart", 32'(fs[0]), 32'd1);
        repeat (45) @(negedge clk);

`ifdef PARITY_EN
        send(32'h0000_0007);
        repeat (40) @(negedge clk);
        check("par7_bit", 32'(od[0]), 32'd1);
        check("par7_last", 32'(lst[0]), 32'd1);
        @(negedge clk);
        check("par7_end", 32'(vld[0]), 32'd0);
        send(32'h0000_0003);
        repeat (40) @(negedge clk);
        check("par3_bit", 32'(od[0]), 32'd0);
        check("par3_last", 32'(lst[0]), 32'd1);
        repeat (5) @(negedge clk);
`endif

        // Random traffic with occasional resets; the per-cycle model check covers it.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = $urandom;
            rst     = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        repeat (50) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
